// File: rtl/boot_img_loader_pkg.sv
// -----------------------------------------------------------------------------
// boot_img_loader_pkg
//   Shared types and constants for the boot-image loader.
//   - state_e     : loader FSM states
//   - CRC_*       : CRC32 polynomial / init / final-XOR constants
//   - crc32_word  : CRC32 update over one 32-bit word, MSB first
//   - bswap32     : byte reversal used on the SRAM write path
// -----------------------------------------------------------------------------
package boot_img_loader_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_e;

    // Non-reflected CRC32, data consumed from bit 31 down to bit 0.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                               input logic [31:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    // Bank0 (bits [7:0]) receives the first byte on the stream (bits [31:24]).
    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/boot_img_crc32.sv
// -----------------------------------------------------------------------------
// boot_img_crc32
//   Registered running CRC32 with synchronous clear and update enable.
//   Ports:
//     clk   in   clock
//     rst_b in   synchronous active-low reset (CRC returns to init value)
//     clr   in   reload init value (wins over en)
//     en    in   fold data into the running CRC
//     data  in   32-bit word, consumed MSB first
//     crc   out  running CRC register (no final XOR applied)
// -----------------------------------------------------------------------------
module boot_img_crc32
    import boot_img_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] data,
    output logic [31:0] crc
);

    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr)     crc_d = CRC_INIT;
        else if (en) crc_d = crc32_word(crc_q, data);
    end

    always_ff @(posedge clk) begin
        if (!rst_b) crc_q <= CRC_INIT;
        else        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/boot_img_loader.sv
// -----------------------------------------------------------------------------
// boot_img_loader
//   Loads a 32-bit word stream into the byte-banked ISRAM, optionally zero-
//   filling the data SRAM first, and holds the CPU in reset until the image is
//   committed. All outputs are registered.
//
//   Build option: define BOOT_IMG_LOADER_CRC_EN to check a CRC32 of the image
//   against crc_exp; without it the check always passes.
//
//   Ports:
//     hclk, hrst_b            clock, synchronous active-low reset
//     start, clr_en, img_len  load request (sampled in IDLE only)
//     crc_exp                 expected image CRC32
//     in_vld, in_data, in_rdy word stream handshake
//     sram_*                  SRAM write port (sram_sel: 0=ISRAM, 1=data SRAM)
//     cpu_rst_b, done, err    boot status
// -----------------------------------------------------------------------------
module boot_img_loader
    import boot_img_loader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 1 << ADDR_W,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              hclk,
    input  logic              hrst_b,
    input  logic              start,
    input  logic              clr_en,
    input  logic [ADDR_W:0]   img_len,
    input  logic [31:0]       crc_exp,
    input  logic              in_vld,
    input  logic [31:0]       in_data,
    output logic              in_rdy,
    output logic              sram_cen_b,
    output logic [3:0]        sram_wen_b,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_sel,
    output logic              cpu_rst_b,
    output logic              done,
    output logic              err
);

    localparam int LEN_W  = ADDR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [IDLE_W-1:0] TMO_L   = IDLE_W'(TIMEOUT_CYC);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    words_q, len_q;
    logic [IDLE_W-1:0]   idle_q;

    logic                in_rdy_q, cen_b_q, sel_q, cpu_rst_b_q, done_q, err_q;
    logic [3:0]          wen_b_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [31:0]         wdata_q;

    logic                hs;
    logic                crc_ok;

    assign hs = (state_q == ST_LOAD) && in_vld && in_rdy_q;

`ifdef BOOT_IMG_LOADER_CRC_EN
    logic [31:0] crc_q, crc_exp_q;

    boot_img_crc32 u_crc (
        .clk   (hclk),
        .rst_b (hrst_b),
        .clr   ((state_q == ST_IDLE) && start),
        .en    (hs),
        .data  (in_data),
        .crc   (crc_q)
    );

    always_ff @(posedge hclk) begin
        if (!hrst_b)                          crc_exp_q <= '0;
        else if (state_q == ST_IDLE && start) crc_exp_q <= crc_exp;
    end

    assign crc_ok = ((crc_q ^ CRC_XOROUT) == crc_exp_q);
`else
    logic unused_crc_exp;
    assign unused_crc_exp = ^crc_exp;
    assign crc_ok         = 1'b1;
`endif

    always_ff @(posedge hclk) begin
        if (!hrst_b) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            words_q     <= '0;
            len_q       <= '0;
            idle_q      <= '0;
            in_rdy_q    <= 1'b0;
            cen_b_q     <= 1'b1;
            wen_b_q     <= 4'hf;
            waddr_q     <= '0;
            wdata_q     <= '0;
            sel_q       <= 1'b0;
            cpu_rst_b_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Write strobes are single-cycle; address/data simply hold.
            cen_b_q <= 1'b1;
            wen_b_q <= 4'hf;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q   <= img_len;
                        words_q <= '0;
                        idle_q  <= '0;
                        addr_q  <= '0;
                        if (img_len == '0 || img_len > DEPTH_L) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else if (clr_en) begin
                            // First zero-fill write goes out on this edge.
                            state_q <= ST_CLEAR;
                            cen_b_q <= 1'b0;
                            wen_b_q <= 4'h0;
                            sel_q   <= 1'b1;
                            waddr_q <= '0;
                            wdata_q <= '0;
                            addr_q  <= ADDR_W'(1);
                        end else begin
                            state_q  <= ST_LOAD;
                            in_rdy_q <= 1'b1;
                        end
                    end
                end

                ST_CLEAR: begin
                    cen_b_q <= 1'b0;
                    wen_b_q <= 4'h0;
                    sel_q   <= 1'b1;
                    waddr_q <= addr_q;
                    wdata_q <= '0;
                    if (addr_q == LAST_A) begin
                        // Last clear write and stream opening share this edge.
                        state_q  <= ST_LOAD;
                        addr_q   <= '0;
                        in_rdy_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end

                ST_LOAD: begin
                    if (hs) begin
                        cen_b_q <= 1'b0;
                        wen_b_q <= 4'h0;
                        sel_q   <= 1'b0;
                        waddr_q <= addr_q;
                        wdata_q <= bswap32(in_data);
                        addr_q  <= addr_q + ADDR_W'(1);
                        words_q <= words_q + LEN_W'(1);
                        idle_q  <= '0;
                        if (words_q + LEN_W'(1) == len_q) begin
                            in_rdy_q <= 1'b0;
                            state_q  <= ST_CHECK;
                        end
                    end else if (idle_q + IDLE_W'(1) == TMO_L) begin
                        in_rdy_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= ST_ERR;
                    end else begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
                end

                // CRC register already holds the last word here.
                ST_CHECK: state_q <= crc_ok ? ST_DONE : ST_ERR;

                ST_DONE: begin
                    done_q      <= 1'b1;
                    cpu_rst_b_q <= 1'b1;
                end

                ST_ERR: begin
                    err_q       <= 1'b1;
                    cpu_rst_b_q <= 1'b0;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_rdy     = in_rdy_q;
    assign sram_cen_b = cen_b_q;
    assign sram_wen_b = wen_b_q;
    assign sram_addr  = waddr_q;
    assign sram_wdata = wdata_q;
    assign sram_sel   = sel_q;
    assign cpu_rst_b  = cpu_rst_b_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_boot_img_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_img_loader
//   Scoreboard bench: every expected SRAM write is queued when the stimulus
//   causes it and checked when the DUT issues it. Status outputs are checked
//   at the cycle the loader is expected to report them.
// -----------------------------------------------------------------------------
module tb_boot_img_loader;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 16384;
    localparam int TMO    = 16;

    logic              hclk = 1'b0;
    logic              hrst_b = 1'b0;
    logic              start = 1'b0;
    logic              clr_en = 1'b0;
    logic [ADDR_W:0]   img_len = '0;
    logic [31:0]       crc_exp = '0;
    logic              in_vld = 1'b0;
    logic [31:0]       in_data = '0;
    logic              in_rdy;
    logic              sram_cen_b;
    logic [3:0]        sram_wen_b;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic              sram_sel;
    logic              cpu_rst_b;
    logic              done;
    logic              err;

    boot_img_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .hclk(hclk), .hrst_b(hrst_b), .start(start), .clr_en(clr_en),
        .img_len(img_len), .crc_exp(crc_exp), .in_vld(in_vld), .in_data(in_data),
        .in_rdy(in_rdy), .sram_cen_b(sram_cen_b), .sram_wen_b(sram_wen_b),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_sel(sram_sel),
        .cpu_rst_b(cpu_rst_b), .done(done), .err(err)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] img[$];
    logic [31:0] first_wd;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_clr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] ref_crc(input logic [31:0] w[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (w[k]) begin
            for (int b = 31; b >= 0; b--) begin
                fb = c[31] ^ w[k][b];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        return ~c;
    endfunction

    // Write monitor / scoreboard pop.
    always @(negedge hclk) begin
        if (sram_cen_b === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sram_wr", {sram_wen_b, sram_sel, sram_addr, sram_wdata},
                    {4'h0, mon_e.sel, mon_e.addr, mon_e.data});
                if (sram_sel) n_clr++;
                if (!sram_sel && sram_addr == '0) first_wd = sram_wdata;
            end
        end
    end

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    // One-cycle reset pulse, outputs checked while reset is held.
    task automatic do_reset;
        hrst_b = 1'b0;
        start  = 1'b0;
        in_vld = 1'b0;
        tick;
        chk("reset_outs",
            {in_rdy, sram_cen_b, sram_wen_b, sram_addr, sram_wdata, sram_sel, cpu_rst_b, done, err},
            {1'b0, 1'b1, 4'hf, 14'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        hrst_b = 1'b1;
    endtask

    task automatic kick(input int len, input bit clr, input logic [31:0] crc);
        img_len = len[ADDR_W:0];
        clr_en  = clr;
        crc_exp = crc;
        start   = 1'b1;
        tick;
        start   = 1'b0;
    endtask

    // Drive img[] over the handshake; ends #1 after the last handshake edge.
    task automatic stream(input bit gap);
        logic [ADDR_W-1:0] a;
        wr_t               e;
        int                t;
        a = '0;
        for (int i = 0; i < img.size(); i++) begin
            in_vld  = 1'b1;
            in_data = img[i];
            t = 0;
            @(negedge hclk);
            while (!in_rdy && t < 20000) begin
                @(negedge hclk);
                t++;
            end
            if (!in_rdy) begin
                chk("rdy_wait", 64'(t), 64'd0);
                in_vld = 1'b0;
                return;
            end
            e.sel  = 1'b0;
            e.addr = a;
            e.data = swap(img[i]);
            exp_q.push_back(e);
            a++;
            @(posedge hclk);
            #1;
            if (gap && i != img.size() - 1) begin
                in_vld  = 1'b0;
                in_data = 32'hDEAD_BEEF;
                tick;
            end
        end
        in_vld = 1'b0;
    endtask

    // Called #1 after the last handshake edge: result shows up 2 edges later.
    task automatic wait_result(input string tag, input bit pass);
        tick;
        chk({tag, "_early"}, {62'h0, done, err}, 64'h0);
        tick;
        chk(tag, {60'h0, done, err, cpu_rst_b, in_rdy},
            pass ? 64'b1010 : 64'b0100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] crc;
        tick;
        do_reset;
        tick;

        // Basic load, correct CRC.
        img = '{32'h1122_3344, 32'hAABB_CCDD, 32'h0, 32'hFFFF_FFFF};
        crc = ref_crc(img);
        kick(4, 1'b0, crc);
        chk("rdy_after_start", {63'h0, in_rdy}, 64'd1);
        stream(1'b0);
        wait_result("basic_done", 1'b1);
        chk("bank0", {56'h0, first_wd[7:0]}, 64'h11);
        chk("bank3", {56'h0, first_wd[31:24]}, 64'h44);
        do_reset;
        tick;

        // Wrong CRC: only rejected when the CRC check is built in.
        kick(4, 1'b0, crc ^ 32'h1);
        stream(1'b0);
`ifdef BOOT_IMG_LOADER_CRC_EN
        wait_result("crc_bad", 1'b0);
`else
        wait_result("crc_ignored", 1'b1);
`endif
        do_reset;
        tick;

        // Clear + single-word load.
        n_clr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mon_e.sel  = 1'b1;
            mon_e.addr = ADDR_W'(i);
            mon_e.data = '0;
            exp_q.push_back(mon_e);
        end
        img = '{32'hCAFE_F00D};
        kick(1, 1'b1, ref_crc(img));
        stream(1'b0);
        wait_result("clear_done", 1'b1);
        chk("clear_count", 64'(n_clr), 64'(DEPTH));
        do_reset;
        tick;

        // Backpressure: in_vld idles every other cycle.
        img = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404,
                32'h0505_0505, 32'h0606_0606, 32'h0707_0707, 32'h0808_0808};
        kick(8, 1'b0, ref_crc(img));
        stream(1'b1);
        wait_result("bp_done", 1'b1);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        do_reset;
        tick;

        // Timeout after two words.
        img = '{32'h1234_5678, 32'h9ABC_DEF0};
        kick(8, 1'b0, 32'h0);
        stream(1'b0);
        repeat (TMO - 1) tick;
        chk("tmo_early", {63'h0, err}, 64'd0);
        tick;
        chk("tmo", {60'h0, err, cpu_rst_b, in_rdy, done}, 64'b1000);
        do_reset;
        tick;

        // Illegal lengths.
        kick(0, 1'b0, 32'h0);
        chk("len0_err", {61'h0, err, cpu_rst_b, done}, 64'b100);
        repeat (3) tick;
        do_reset;
        tick;
        kick(DEPTH + 1, 1'b1, 32'h0);
        chk("lenmax_err", {61'h0, err, cpu_rst_b, done}, 64'b100);
        repeat (3) tick;
        do_reset;
        tick;

        // Reset in the middle of a load, then a clean reload.
        img = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
        kick(8, 1'b0, 32'h0);
        stream(1'b0);
        tick;
        do_reset;
        chk("midrst_q", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick;
        img = '{32'h1122_3344, 32'hAABB_CCDD, 32'h0, 32'hFFFF_FFFF};
        kick(4, 1'b0, ref_crc(img));
        stream(1'b0);
        wait_result("reload_done", 1'b1);
        repeat (2) tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
